// File: rtl/way.sv
// rtl/way.sv - single-way, set-indexed translation entry store with PCID invalidate
//
// Purpose: NSET entries of {valid, tag, pcid, pa}. Lookup is combinational on
// rd_set; writes and invalidate-by-PCID take effect on the rising clock edge.
//
// Ports:
//    clk       sole clock
//    rst       synchronous active-high reset, clears every entry completely
//    rd_set    set index for lookup
//    rd_tag    tag compared against the addressed entry
//    rd_pcid   PCID compared against the addressed entry
//    rd_hit    valid and tag and pcid all match
//    rd_pa     stored page number of the addressed set (not qualified by hit)
//    rd_valid  valid bit of the addressed set
//    we        write enable
//    wr_set    set index to write
//    wr_tag    tag to write
//    wr_pcid   PCID to write
//    wr_pa     page number to write
//    inv_en    invalidate every valid entry whose pcid equals inv_pcid
//    inv_pcid  PCID to invalidate
module way #(
   parameter  int SADDR = 64,
   parameter  int SPAGE = 12,
   parameter  int NSET  = 8,
   parameter  int SPCID = 12,
   localparam int SW    = $clog2(NSET),
   localparam int TW    = SADDR - SPAGE - SW,
   localparam int PW    = SADDR - SPAGE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SW-1:0]    rd_set,
   input  logic [TW-1:0]    rd_tag,
   input  logic [SPCID-1:0] rd_pcid,
   output logic             rd_hit,
   output logic [PW-1:0]    rd_pa,
   output logic             rd_valid,
   input  logic             we,
   input  logic [SW-1:0]    wr_set,
   input  logic [TW-1:0]    wr_tag,
   input  logic [SPCID-1:0] wr_pcid,
   input  logic [PW-1:0]    wr_pa,
   input  logic             inv_en,
   input  logic [SPCID-1:0] inv_pcid
);

   logic [NSET-1:0] r_valid;
   logic [TW-1:0]    r_tag  [NSET];
   logic [SPCID-1:0] r_pcid [NSET];
   logic [PW-1:0]    r_pa   [NSET];

   logic w_tag_eq;
   logic w_pcid_eq;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSET; i++) begin
            r_valid[i] <= 1'b0;
            r_tag[i]   <= '0;
            r_pcid[i]  <= '0;
            r_pa[i]    <= '0;
         end
      end else begin
         // Invalidate only clears valid; contents stay readable on rd_pa.
         for (int i = 0; i < NSET; i++) begin
            if (inv_en && r_valid[i] && (r_pcid[i] == inv_pcid)) begin
               r_valid[i] <= 1'b0;
            end
         end
         // Placed after the invalidate loop so a simultaneous write wins.
         if (we) begin
            r_valid[wr_set] <= 1'b1;
            r_tag[wr_set]   <= wr_tag;
            r_pcid[wr_set]  <= wr_pcid;
            r_pa[wr_set]    <= wr_pa;
         end
      end
   end

   assign w_tag_eq  = (r_tag[rd_set] == rd_tag);
   assign w_pcid_eq = (r_pcid[rd_set] == rd_pcid);

   assign rd_valid = r_valid[rd_set];
   assign rd_pa    = r_pa[rd_set];
   assign rd_hit   = r_valid[rd_set] && w_tag_eq && w_pcid_eq;

endmodule

// File: tb/tb_way.sv
// tb/tb_way.sv - scoreboard testbench for way
module tb_way;

   localparam int SADDR = 64;
   localparam int SPAGE = 12;
   localparam int NSET  = 8;
   localparam int SPCID = 12;
   localparam int SW    = $clog2(NSET);
   localparam int TW    = SADDR - SPAGE - SW;
   localparam int PW    = SADDR - SPAGE;

   typedef struct {
      logic          hit;
      logic          valid;
      logic [PW-1:0] pa;
      string         name;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [SW-1:0]    rd_set = '0;
   logic [TW-1:0]    rd_tag = '0;
   logic [SPCID-1:0] rd_pcid = '0;
   logic             rd_hit;
   logic [PW-1:0]    rd_pa;
   logic             rd_valid;
   logic             we = 1'b0;
   logic [SW-1:0]    wr_set = '0;
   logic [TW-1:0]    wr_tag = '0;
   logic [SPCID-1:0] wr_pcid = '0;
   logic [PW-1:0]    wr_pa = '0;
   logic             inv_en = 1'b0;
   logic [SPCID-1:0] inv_pcid = '0;

   logic look_en = 1'b0;
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   way #(.SADDR(SADDR), .SPAGE(SPAGE), .NSET(NSET), .SPCID(SPCID)) dut (
      .clk(clk), .rst(rst),
      .rd_set(rd_set), .rd_tag(rd_tag), .rd_pcid(rd_pcid),
      .rd_hit(rd_hit), .rd_pa(rd_pa), .rd_valid(rd_valid),
      .we(we), .wr_set(wr_set), .wr_tag(wr_tag), .wr_pcid(wr_pcid), .wr_pa(wr_pa),
      .inv_en(inv_en), .inv_pcid(inv_pcid)
   );

   always #5 clk = ~clk;

   // Monitor: lookups are presented for one cycle; sample mid-cycle.
   always @(negedge clk) begin
      if (look_en) begin
         exp_t e;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: lookup presented with no expectation queued");
         end else begin
            e = sb_q.pop_front();
            if (rd_hit !== e.hit || rd_valid !== e.valid || rd_pa !== e.pa) begin
               errors++;
               $display("FAIL %s: got hit=%b valid=%b pa=%h, expected hit=%b valid=%b pa=%h",
                        e.name, rd_hit, rd_valid, rd_pa, e.hit, e.valid, e.pa);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one lookup for one cycle; any we/inv_en/rst set by the caller
   // takes effect on the edge that closes this cycle.
   task automatic look(input logic [SW-1:0] s, input logic [TW-1:0] t,
                       input logic [SPCID-1:0] p, input logic e_hit,
                       input logic e_valid, input logic [PW-1:0] e_pa,
                       input string name);
      exp_t e;
      rd_set  = s;
      rd_tag  = t;
      rd_pcid = p;
      e.hit = e_hit; e.valid = e_valid; e.pa = e_pa; e.name = name;
      sb_q.push_back(e);
      look_en = 1'b1;
      @(posedge clk);
      #1;
      look_en = 1'b0;
   endtask

   task automatic set_wr(input logic [SW-1:0] s, input logic [TW-1:0] t,
                         input logic [SPCID-1:0] p, input logic [PW-1:0] a);
      we = 1'b1; wr_set = s; wr_tag = t; wr_pcid = p; wr_pa = a;
   endtask

   task automatic clr_ctl();
      we = 1'b0; inv_en = 1'b0; rst = 1'b0;
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      look(0, 0, 0, 0, 0, 0, "reset_set0_zero_lookup");
      for (int i = 1; i < NSET; i++) look(SW'(i), 0, 0, 0, 0, 0, "reset_all_sets");

      // Write set 3, same-cycle lookup returns old contents
      set_wr(3, TW'('h1A2B), 12'h005, PW'('hABCDE));
      look(3, TW'('h1A2B), 12'h005, 0, 0, 0, "write_same_cycle_old");
      clr_ctl();
      look(3, TW'('h1A2B), 12'h005, 1, 1, PW'('hABCDE), "write_then_hit");
      look(3, TW'('h1A2B), 12'h006, 0, 1, PW'('hABCDE), "pcid_mismatch");
      look(3, TW'('h1A2C), 12'h005, 0, 1, PW'('hABCDE), "tag_mismatch");
      look(2, 0, 0, 0, 0, 0, "neighbour_untouched");

      // Fill all sets with pcid 7
      for (int i = 0; i < NSET; i++) begin
         set_wr(SW'(i), TW'(i + 1), 12'h007, PW'(32'h100 + i));
         tick();
      end
      clr_ctl();
      for (int i = 0; i < NSET; i++)
         look(SW'(i), TW'(i + 1), 12'h007, 1, 1, PW'(32'h100 + i), "fill_hit");

      // Invalidate pcid 7 with simultaneous write to set 2
      inv_en = 1'b1; inv_pcid = 12'h007;
      set_wr(2, TW'('h55), 12'h007, PW'('h222));
      look(2, TW'(3), 12'h007, 1, 1, PW'('h102), "inv_write_same_cycle_old");
      clr_ctl();
      look(2, TW'('h55), 12'h007, 1, 1, PW'('h222), "write_wins_over_inv");
      for (int i = 0; i < NSET; i++)
         if (i != 2) look(SW'(i), TW'(i + 1), 12'h007, 0, 0, PW'(32'h100 + i), "inv_cleared_pa_kept");

      // Invalidate leaves other PCIDs alone
      set_wr(0, TW'('h77), 12'h009, PW'('h300));
      tick();
      clr_ctl();
      inv_en = 1'b1; inv_pcid = 12'h007;
      tick();
      clr_ctl();
      look(0, TW'('h77), 12'h009, 1, 1, PW'('h300), "inv_other_pcid_kept");
      look(2, TW'('h55), 12'h007, 0, 0, PW'('h222), "inv_set2_cleared");

      // Read-before-write on set 5 after reset
      rst = 1'b1;
      tick();
      clr_ctl();
      set_wr(5, TW'('h10), 12'h001, PW'('h55555));
      look(5, TW'('h10), 12'h001, 0, 0, 0, "rbw_old_value");
      clr_ctl();
      look(5, TW'('h10), 12'h001, 1, 1, PW'('h55555), "rbw_new_value");

      // Overwrite of a valid entry
      set_wr(5, TW'('h11), 12'h001, PW'('h66));
      tick();
      clr_ctl();
      look(5, TW'('h10), 12'h001, 0, 1, PW'('h66), "overwrite_old_tag_miss");
      look(5, TW'('h11), 12'h001, 1, 1, PW'('h66), "overwrite_new_tag_hit");

      // Reset beats a same-cycle write
      set_wr(1, TW'('h21), 12'h003, PW'('hAAA));
      tick();
      set_wr(4, TW'('h24), 12'h003, PW'('hBBB));
      tick();
      clr_ctl();
      look(1, TW'('h21), 12'h003, 1, 1, PW'('hAAA), "pre_rst_set1");
      look(4, TW'('h24), 12'h003, 1, 1, PW'('hBBB), "pre_rst_set4");
      rst = 1'b1;
      set_wr(6, TW'('h26), 12'h003, PW'('hCCC));
      tick();
      clr_ctl();
      look(1, TW'('h21), 12'h003, 0, 0, 0, "rst_clears_set1");
      look(4, TW'('h24), 12'h003, 0, 0, 0, "rst_clears_set4");
      look(6, TW'('h26), 12'h003, 0, 0, 0, "rst_beats_write_set6");
      look(5, 0, 0, 0, 0, 0, "rst_zero_tag_no_hit");

      tick();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
